// File: rtl/addsub8_seq.sv
// addsub8_seq: 8-bit add/subtract built from a single 2-bit adder slice
// reused over four cycles; result, carry and overflow are registered at the end.
module addsub8_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       k,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum,
    output logic       c_out,
    output logic       ovf,
    output logic [1:0] slice
);
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] work;
    logic [DATA_W-1:0] work_nxt;
    logic              carry;
    logic [1:0]        idx;
    logic [2:0]        slice_res;
    logic              accept;
    logic              last;

    // The only adder in the block: two bits plus carry-in, carry-out in bit 2.
    function automatic logic [2:0] add2(input logic [1:0] x, input logic [1:0] y,
                                        input logic ci);
        return {1'b0, x} + {1'b0, y} + {2'b00, ci};
    endfunction

    assign slice_res = add2(op_a[{idx, 1'b0} +: 2], op_b[{idx, 1'b0} +: 2], carry);
    assign accept    = (state == IDLE) && start;
    assign last      = (state == RUN) && (idx == 2'd3);

    always_comb begin
        work_nxt                    = work;
        work_nxt[{idx, 1'b0} +: 2]  = slice_res[1:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (idx == 2'd3) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Subtraction is A + ~B + 1: operand B is inverted at latch time and k seeds the carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            idx   <= 2'd0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {DATA_W{k}};
            work  <= '0;
            carry <= k;
            idx   <= 2'd0;
        end else if (state == RUN) begin
            work  <= work_nxt;
            carry <= slice_res[2];
            idx   <= idx + 2'd1;
            if (last) begin
                sum   <= work_nxt;
                c_out <= slice_res[2];
                ovf   <= (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                         (work_nxt[DATA_W-1] != op_a[DATA_W-1]);
            end
        end
    end

    assign busy  = (state == RUN);
    assign done  = (state == DONE);
    assign slice = busy ? idx : 2'd0;
endmodule

// File: tb/tb_addsub8_seq.sv
// Self-checking bench for addsub8_seq: expected results are queued at operand
// launch and compared when done pulses.
module tb_addsub8_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       k = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;
    logic [1:0] slice;

    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         cyc = 0;
    logic [9:0] exp_q[$];
    logic [9:0] held = 10'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    addsub8_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .k    (k),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .c_out(c_out),
        .ovf  (ovf),
        .slice(slice)
    );

    // Reference: plain 9-bit arithmetic, returns {sum, c_out, ovf}.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic m);
        logic [7:0] yp;
        logic [8:0] t;
        yp = y ^ {8{m}};
        t  = {1'b0, x} + {1'b0, yp} + {8'd0, m};
        return {t[7:0], t[8], (x[7] == yp[7]) && (t[7] != x[7])};
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tk,
                          input bit disturb);
        logic [9:0] e;
        logic [1:0] cs;
        int n;
        a = ta; b = tb; k = tk; start = 1'b1;
        exp_q.push_back(model(ta, tb, tk));
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cs = c[1:0];
            chk_cnt++; if (busy !== 1'b1) $display("FAIL run_busy c=%0d: got %b want 1", c, busy); else pass_cnt++;
            chk_cnt++; if (slice !== cs) $display("FAIL run_slice: got %0d want %0d", slice, cs); else pass_cnt++;
            chk_cnt++; if (done !== 1'b0) $display("FAIL run_done c=%0d: got %b want 0", c, done); else pass_cnt++;
            chk_cnt++; if ({sum, c_out, ovf} !== held) $display("FAIL held_result c=%0d: got %h want %h", c, {sum, c_out, ovf}, held); else pass_cnt++;
            if (disturb) begin
                a = ~ta; b = ta; k = ~tk; start = (c < 2);
            end
            if (c < 3) begin @(posedge clk); #1; end
        end
        start = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < 10);
        chk_cnt++; if (n != 1) $display("FAIL done_latency: got %0d extra cycles want 1", n); else pass_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
        if (done === 1'b1) begin
            chk_cnt++; if ({sum, c_out, ovf} !== e) $display("FAIL result a=%h b=%h k=%b: got %h want %h", ta, tb, tk, {sum, c_out, ovf}, e); else pass_cnt++;
            chk_cnt++; if ({busy, slice} !== 3'b000) $display("FAIL done_idle_outputs: got %b want 000", {busy, slice}); else pass_cnt++;
        end
        held = e;
        @(posedge clk); #1;
        chk_cnt++; if (done !== 1'b0) $display("FAIL done_width: got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        #1;
        chk_cnt++; if ({busy, done, sum, c_out, ovf, slice} !== 14'd0) $display("FAIL reset_async: got %h want 0", {busy, done, sum, c_out, ovf, slice}); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if ({busy, done, sum, c_out, ovf, slice} !== 14'd0) $display("FAIL reset_clocked: got %h want 0", {busy, done, sum, c_out, ovf, slice}); else pass_cnt++;
        start = 1'b0;
        #2 rst = 1'b0;
        held = 10'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_op(8'h35, 8'h4A, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        run_op(8'h10, 8'h20, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(8'h12, 8'h34, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL no_requeue i=%0d: got %b want 00", i, {done, busy}); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        a = 8'h55; b = 8'h22; k = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h55, 8'h22, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_cnt++; if (slice !== 2'd2) $display("FAIL mid_slice: got %0d want 2", slice); else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++; if ({busy, done, sum, c_out, ovf, slice} !== 14'd0) $display("FAIL mid_reset_async: got %h want 0", {busy, done, sum, c_out, ovf, slice}); else pass_cnt++;
        void'(exp_q.pop_back());
        held = 10'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_cnt++; if ({done, busy} !== 2'b00) $display("FAIL mid_no_done i=%0d: got %b want 00", i, {done, busy}); else pass_cnt++;
        end
        run_op(8'h01, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[4] = '{8'h11, 8'hF0, 8'h80, 8'h3C};
        logic [7:0] vb[4] = '{8'h22, 8'h20, 8'h7F, 8'h3C};
        logic       vk[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0] e;
        int n;
        int last_cyc;
        last_cyc = 0;
        a = va[0]; b = vb[0]; k = vk[0]; start = 1'b1;
        exp_q.push_back(model(va[0], vb[0], vk[0]));
        for (int i = 0; i < 4; i++) begin
            n = 0;
            do begin @(posedge clk); #1; n++; end while (done !== 1'b1 && n < 12);
            chk_cnt++; if (done !== 1'b1) $display("FAIL b2b_done_seen i=%0d: got %b want 1", i, done); else pass_cnt++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
            chk_cnt++; if ({sum, c_out, ovf} !== e) $display("FAIL b2b_result i=%0d: got %h want %h", i, {sum, c_out, ovf}, e); else pass_cnt++;
            held = e;
            if (i > 0) begin
                chk_cnt++; if (cyc - last_cyc != 6) $display("FAIL b2b_period i=%0d: got %0d want 6", i, cyc - last_cyc); else pass_cnt++;
            end
            last_cyc = cyc;
            if (i < 3) begin
                a = va[i+1]; b = vb[i+1]; k = vk[i+1];
                exp_q.push_back(model(va[i+1], vb[i+1], vk[i+1]));
            end
            @(posedge clk); #1;
            chk_cnt++; if (done !== 1'b0) $display("FAIL b2b_consecutive_done i=%0d: got %b want 0", i, done); else pass_cnt++;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
